// File: rtl/lut_layer_pkg.sv
// Shared types and sizing helpers for the LUT layer pipeline.
package lut_layer_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    // Neuron counter needs at least one bit even for a single-neuron layer.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// One neuron's truth table: 2**IN_BITS x OUT_BITS distributed RAM, sync write, async read.
module lut_table_ram #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [IN_BITS-1:0]  waddr_i,
    input  logic [OUT_BITS-1:0] wdata_i,
    input  logic [IN_BITS-1:0]  raddr_i,
    output logic [OUT_BITS-1:0] rdata_o
);

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [OUT_BITS-1:0] mem_q [2**IN_BITS];

    // Contents are deliberately not reset; they survive until reloaded.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lut_layer_pipe.sv
// Pipelined layer of run-time loadable neuron LUTs with valid/ready data path and a streaming table loader.
module lut_layer_pipe
    import lut_layer_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                          cfg_start,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [OUT_BITS-1:0]           cfg_data,
    output logic                          cfg_done
);

    localparam int                 NRN_W     = cnt_width(N_NEURONS);
    localparam logic [NRN_W-1:0]   NRN_LAST  = NRN_W'(N_NEURONS - 1);
    localparam logic [IN_BITS-1:0] ADDR_LAST = '1;

    state_e                          state_q, state_d;
    logic [NRN_W-1:0]                nrn_cnt_q, nrn_cnt_d;
    logic [IN_BITS-1:0]              addr_cnt_q, addr_cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [N_NEURONS*OUT_BITS-1:0]   out_data_q, out_data_d;
    logic                            cfg_done_q, cfg_done_d;

    logic                            in_xfer;
    logic                            load_acc;
    logic                            load_last;
    logic [N_NEURONS-1:0]            ram_we;
    logic [N_NEURONS*OUT_BITS-1:0]   lookup_data;

    assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign cfg_ready = (state_q == ST_LOAD);
    assign in_xfer   = in_valid && in_ready;
    assign load_acc  = cfg_valid && cfg_ready;
    assign load_last = (nrn_cnt_q == NRN_LAST) && (addr_cnt_q == ADDR_LAST);

    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            assign ram_we[gi] = load_acc && (nrn_cnt_q == NRN_W'(gi));

            lut_table_ram #(
                .IN_BITS  (IN_BITS),
                .OUT_BITS (OUT_BITS)
            ) u_table (
                .clk_i   (clk),
                .we_i    (ram_we[gi]),
                .waddr_i (addr_cnt_q),
                .wdata_i (cfg_data),
                .raddr_i (in_data[gi*IN_BITS +: IN_BITS]),
                .rdata_o (lookup_data[gi*OUT_BITS +: OUT_BITS])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        nrn_cnt_d   = nrn_cnt_q;
        addr_cnt_d  = addr_cnt_q;
        cfg_done_d  = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_RUN: begin
                if (cfg_start) begin
                    state_d    = ST_LOAD;
                    nrn_cnt_d  = '0;
                    addr_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_acc) begin
                    // Address wraps naturally at its width; neuron advances on that wrap.
                    addr_cnt_d = addr_cnt_q + IN_BITS'(1);
                    if (addr_cnt_q == ADDR_LAST) begin
                        nrn_cnt_d = nrn_cnt_q + NRN_W'(1);
                    end
                    if (load_last) begin
                        state_d    = ST_RUN;
                        cfg_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = lookup_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            nrn_cnt_q   <= '0;
            addr_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nrn_cnt_q   <= nrn_cnt_d;
            addr_cnt_q  <= addr_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_done_q  <= cfg_done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Directed bench for lut_layer_pipe: table loads, lookups, back-pressure, load under held output, reset mid-load.
module tb_lut_layer_pipe;

    localparam int N = 4;
    localparam int IB = 8;
    localparam int OB = 1;
    localparam int DEPTH = 2**IB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N*IB-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N*OB-1:0] out_data;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [OB-1:0] cfg_data = '0;
    logic          cfg_done;

    int compared = 0;
    int mismatched = 0;

    lut_layer_pipe #(
        .N_NEURONS (N),
        .IN_BITS   (IB),
        .OUT_BITS  (OB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done)
    );

    always #5 clk = ~clk;

    // Table pattern 0: k[a]=a[4]^a[k]; 1: a[0]^a[7]^(k==1); 2: inverse of pattern 0.
    function automatic logic tbl_bit(input int pat, input int k, input int a);
        logic [7:0] av;
        av = 8'(a);
        case (pat)
            0:       return av[4] ^ av[k];
            1:       return av[0] ^ av[7] ^ (k == 1);
            default: return ~(av[4] ^ av[k]);
        endcase
    endfunction

    function automatic logic [N-1:0] model(input int pat, input logic [N*IB-1:0] d);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = tbl_bit(pat, k, int'(d[k*IB +: IB]));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams nwords entries; full loads also check the cfg_done timing.
    task automatic load(input int pat, input int nwords, input bit held_chk, input logic [N-1:0] held_val);
        int k, a;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("cfg_ready_in_load", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < nwords; i++) begin
            if (i == 500) begin
                cfg_valid = 1'b0;
                tick();
            end
            k = i / DEPTH;
            a = i % DEPTH;
            cfg_valid = 1'b1;
            cfg_data  = (pat == 1 && nwords < N*DEPTH) ? ~tbl_bit(1, k, a) : tbl_bit(pat, k, a);
            tick();
            if (i == N*DEPTH - 2) check("cfg_done_early", 32'(cfg_done), 32'd0);
            if (held_chk && (i % 256 == 128)) begin
                check("in_ready_during_load", 32'(in_ready), 32'd0);
                check("held_data_during_load", 32'(out_data), 32'(held_val));
            end
        end
        cfg_valid = 1'b0;
        if (nwords == N*DEPTH) begin
            check("cfg_done_pulse", 32'(cfg_done), 32'd1);
            check("cfg_ready_after_load", 32'(cfg_ready), 32'd0);
            tick();
            check("cfg_done_one_cycle", 32'(cfg_done), 32'd0);
        end
    endtask

    initial begin
        logic [N*IB-1:0] vec, prev, x, y, z;

        // 1: reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_cfg_done", 32'(cfg_done), 32'd0);
        rst_n = 1'b1;
        tick();

        // 2: full load of pattern 0
        load(0, N*DEPTH, 1'b0, '0);

        // 3: single lookup, then back-to-back stream
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {8'h10, 8'h20, 8'h04, 8'h11};
        tick();
        check("lookup_valid", 32'(out_valid), 32'd1);
        check("lookup_data_hand", 32'(out_data), 32'h8);
        prev = in_data;
        for (int i = 0; i < 8; i++) begin
            vec = 32'h1f3a5c27 * (i + 3) ^ 32'(i * 32'h01010101);
            in_data = vec;
            #1;
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            tick();
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_data", 32'(out_data), 32'(model(0, vec)));
            prev = vec;
        end

        // 4: back-pressure holds output; pending input taken on release
        x = 32'hA5_3C_F0_0F;
        y = 32'h5A_C3_0F_F0;
        in_data = x;
        tick();
        check("bp_first", 32'(out_data), 32'(model(0, x)));
        out_ready = 1'b0;
        in_data   = y;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'(model(0, x)));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_pending_data", 32'(out_data), 32'(model(0, y)));
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // 5: load pattern 2 while an output is held
        z = 32'h13_57_9B_DF;
        in_valid = 1'b1;
        in_data  = z;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        load(2, N*DEPTH, 1'b1, model(0, z));
        check("held_valid_after_load", 32'(out_valid), 32'd1);
        check("held_data_after_load", 32'(out_data), 32'(model(0, z)));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        check("new_table_lookup", 32'(out_data), 32'(model(2, z)));
        in_valid = 1'b0;
        tick();

        // 6: reset mid-load, then full reload of pattern 1
        load(1, 300, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        load(1, N*DEPTH, 1'b0, '0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vec = (i == 0) ? 32'h00_00_00_00 : (32'h9e3779b9 * i);
            in_data = vec;
            tick();
            check("reload_lookup", 32'(out_data), 32'(model(1, vec)));
        end
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
